// File: rtl/segway_sequencer.sv
// Power-up / mode sequencer for the Segway balance datapath: soft-start ramp,
// steer qualification, rider step-off pulse and latched overspeed shutdown.
module segway_sequencer #(
    parameter int SS_DIV    = 16,
    parameter int SS_STEP   = 1,
    parameter int STEER_DLY = 256,
    parameter int FAST_LIM  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_req,
    input  logic       sum_gt_min,
    input  logic       diff_small,
    input  logic       too_fast,
    output logic       pwr_up,
    output logic [7:0] ss_tmr,
    output logic       en_steer,
    output logic       rider_off,
    output logic       fault,
    output logic [2:0] dbg_state
);

    // dbg_state encoding: OFF=0, RAMP=1, BALANCE=2, STEER=3, FAULT=4
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RAMP    = 3'd1,
        ST_BALANCE = 3'd2,
        ST_STEER   = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam int PS_W    = $clog2(SS_DIV);
    localparam int STEER_W = $clog2(STEER_DLY + 1);
    localparam int FAST_W  = $clog2(FAST_LIM + 1);

    localparam logic [PS_W-1:0]    PS_LAST    = PS_W'(SS_DIV - 1);
    localparam logic [STEER_W-1:0] STEER_LAST = STEER_W'(STEER_DLY - 1);
    localparam logic [FAST_W-1:0]  FAST_MAX   = FAST_W'(FAST_LIM);
    localparam logic [8:0]         STEP9      = 9'(SS_STEP);

    state_t              state_q, state_d;
    logic [7:0]          ss_q, ss_d;
    logic [PS_W-1:0]     ps_q, ps_d;
    logic [STEER_W-1:0]  steer_q, steer_d;
    logic [FAST_W-1:0]   fast_q, fast_d;
    logic                pwr_up_q, pwr_up_d;
    logic                en_steer_q, en_steer_d;
    logic                rider_off_q, rider_off_d;
    logic                fault_q, fault_d;

    logic                active;
    logic                trip;
    logic [FAST_W-1:0]   fast_inc;
    logic [8:0]          sum9;
    logic [7:0]          ss_sat;

    always_comb begin
        state_d     = state_q;
        ss_d        = ss_q;
        ps_d        = ps_q;
        steer_d     = steer_q;
        fast_d      = '0;
        rider_off_d = 1'b0;

        active   = (state_q == ST_RAMP) || (state_q == ST_BALANCE) || (state_q == ST_STEER);
        fast_inc = (fast_q == FAST_MAX) ? fast_q : fast_q + FAST_W'(1);
        if (active && too_fast) begin
            fast_d = fast_inc;
        end
        // Trip is judged on the count including this cycle's too_fast sample.
        trip = active && too_fast && (fast_inc == FAST_MAX);

        // Nine-bit sum so a large step saturates at 255 instead of wrapping.
        sum9   = {1'b0, ss_q} + STEP9;
        ss_sat = sum9[8] ? 8'hFF : sum9[7:0];

        if ((state_q != ST_OFF) && !pwr_req) begin
            state_d = ST_OFF;
            ss_d    = '0;
            ps_d    = '0;
            steer_d = '0;
            fast_d  = '0;
        end else if (trip) begin
            state_d = ST_FAULT;
            ss_d    = '0;
            ps_d    = '0;
            steer_d = '0;
            fast_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    ss_d    = '0;
                    ps_d    = '0;
                    steer_d = '0;
                    if (pwr_req) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (ps_q == PS_LAST) begin
                        ps_d = '0;
                        ss_d = ss_sat;
                        if (ss_sat == 8'hFF) begin
                            state_d = ST_BALANCE;
                            steer_d = '0;
                        end
                    end else begin
                        ps_d = ps_q + PS_W'(1);
                    end
                end
                ST_BALANCE: begin
                    ss_d = 8'hFF;
                    if (sum_gt_min && diff_small) begin
                        if (steer_q == STEER_LAST) begin
                            state_d = ST_STEER;
                            steer_d = '0;
                        end else begin
                            steer_d = steer_q + STEER_W'(1);
                        end
                    end else begin
                        steer_d = '0;
                    end
                end
                ST_STEER: begin
                    ss_d = 8'hFF;
                    if (!sum_gt_min) begin
                        state_d     = ST_BALANCE;
                        rider_off_d = 1'b1;
                        steer_d     = '0;
                    end
                end
                ST_FAULT: begin
                    ss_d = '0;
                end
                default: begin
                    state_d = ST_OFF;
                    ss_d    = '0;
                    ps_d    = '0;
                    steer_d = '0;
                end
            endcase
        end

        pwr_up_d   = (state_d == ST_RAMP) || (state_d == ST_BALANCE) || (state_d == ST_STEER);
        en_steer_d = (state_d == ST_STEER);
        fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            ss_q        <= '0;
            ps_q        <= '0;
            steer_q     <= '0;
            fast_q      <= '0;
            pwr_up_q    <= 1'b0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_q        <= ss_d;
            ps_q        <= ps_d;
            steer_q     <= steer_d;
            fast_q      <= fast_d;
            pwr_up_q    <= pwr_up_d;
            en_steer_q  <= en_steer_d;
            rider_off_q <= rider_off_d;
            fault_q     <= fault_d;
        end
    end

    assign pwr_up    = pwr_up_q;
    assign ss_tmr    = ss_q;
    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;
    assign fault     = fault_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_segway_sequencer.sv
// Bench for segway_sequencer: directed vector table on a default instance,
// ramp-saturation and random-vs-model checks on a small-parameter instance.
module tb_segway_sequencer;

    localparam logic [2:0] S_OFF = 3'd0, S_RAMP = 3'd1, S_BAL = 3'd2, S_STEER = 3'd3, S_FAULT = 3'd4;
    localparam int R_DIV = 4, R_STEP = 100, R_DLY = 5, R_LIM = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default-parameter instance
    logic p, s, d, t;
    logic d_pu, d_en, d_ro, d_f;
    logic [7:0] d_ss;
    logic [2:0] d_state;

    // small-parameter instance
    logic rp, rs, rd, rt;
    logic r_pu, r_en, r_ro, r_f;
    logic [7:0] r_ss;
    logic [2:0] r_state;

    segway_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .pwr_req(p), .sum_gt_min(s), .diff_small(d), .too_fast(t),
        .pwr_up(d_pu), .ss_tmr(d_ss), .en_steer(d_en), .rider_off(d_ro), .fault(d_f),
        .dbg_state(d_state)
    );

    segway_sequencer #(.SS_DIV(R_DIV), .SS_STEP(R_STEP), .STEER_DLY(R_DLY), .FAST_LIM(R_LIM)) u_sat (
        .clk(clk), .rst_n(rst_n), .pwr_req(rp), .sum_gt_min(rs), .diff_small(rd), .too_fast(rt),
        .pwr_up(r_pu), .ss_tmr(r_ss), .en_steer(r_en), .rider_off(r_ro), .fault(r_f),
        .dbg_state(r_state)
    );

    typedef struct {
        logic       p, s, d, t;
        int         n;
        logic       pu;
        logic [7:0] ss;
        logic       en, ro, f;
        logic [2:0] st;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic ip, is, id, it, input int n,
                                input logic pu, input logic [7:0] ss,
                                input logic en, ro, f, input logic [2:0] st);
        vec_t v;
        v.p = ip; v.s = is; v.d = id; v.t = it; v.n = n;
        v.pu = pu; v.ss = ss; v.en = en; v.ro = ro; v.f = f; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step_d(input logic ip, is, id, it);
        @(negedge clk);
        p = ip; s = is; d = id; t = it;
        @(posedge clk);
        #1;
    endtask

    task automatic step_r(input logic ip, is, id, it);
        @(negedge clk);
        rp = ip; rs = is; rd = id; rt = it;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] d_bundle();
        return {1'b0, d_state, d_pu, d_ss, d_en, d_ro, d_f};
    endfunction

    function automatic logic [15:0] r_bundle();
        return {1'b0, r_state, r_pu, r_ss, r_en, r_ro, r_f};
    endfunction

    // Behavioural model of the small instance: ramp level from elapsed ramp
    // cycles, steer and overspeed as run lengths of their input conditions.
    int m_mode, m_ramp, m_run, m_fast;
    logic m_ro;

    function automatic int ramp_level(input int n);
        int v;
        v = (n / R_DIV) * R_STEP;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_step(input logic ip, is, id, it);
        bit act;
        act  = (m_mode == 1) || (m_mode == 2) || (m_mode == 3);
        m_ro = 1'b0;
        if (act) m_fast = it ? ((m_fast + 1 > R_LIM) ? R_LIM : m_fast + 1) : 0;
        else     m_fast = 0;
        if (m_mode != 0 && !ip) begin
            m_mode = 0; m_fast = 0;
        end else if (act && m_fast == R_LIM) begin
            m_mode = 4; m_fast = 0;
        end else begin
            case (m_mode)
                0: if (ip) begin m_mode = 1; m_ramp = 0; end
                1: begin
                    m_ramp++;
                    if (ramp_level(m_ramp) == 255) begin m_mode = 2; m_run = 0; end
                end
                2: if (is && id) begin
                    m_run++;
                    if (m_run == R_DLY) begin m_mode = 3; m_run = 0; end
                end else m_run = 0;
                3: if (!is) begin m_mode = 2; m_ro = 1'b1; m_run = 0; end
                default: ;
            endcase
        end
    endtask

    function automatic logic [11:0] model_out();
        logic [7:0] ss;
        ss = (m_mode == 1) ? 8'(ramp_level(m_ramp)) : ((m_mode == 2 || m_mode == 3) ? 8'hFF : 8'h00);
        return {(m_mode >= 1 && m_mode <= 3) ? 1'b1 : 1'b0, ss, (m_mode == 3) ? 1'b1 : 1'b0,
                m_ro, (m_mode == 4) ? 1'b1 : 1'b0};
    endfunction

    initial begin
        p = 0; s = 0; d = 0; t = 0;
        rp = 0; rs = 0; rd = 0; rt = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_default", d_bundle(), 16'h0000);
        check("reset_small", r_bundle(), 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // power-up ramp
        vt.push_back(mk(1,0,0,0,1,    1,8'd0,  0,0,0,S_RAMP));
        vt.push_back(mk(1,0,0,0,15,   1,8'd0,  0,0,0,S_RAMP));
        vt.push_back(mk(1,0,0,0,1,    1,8'd1,  0,0,0,S_RAMP));
        vt.push_back(mk(1,0,0,0,16,   1,8'd2,  0,0,0,S_RAMP));
        vt.push_back(mk(1,0,0,0,4047, 1,8'd254,0,0,0,S_RAMP));
        vt.push_back(mk(1,0,0,0,1,    1,8'd255,0,0,0,S_BAL));
        // steer qualification with a one-cycle break
        vt.push_back(mk(1,1,1,0,200,  1,8'd255,0,0,0,S_BAL));
        vt.push_back(mk(1,1,0,0,1,    1,8'd255,0,0,0,S_BAL));
        vt.push_back(mk(1,1,1,0,255,  1,8'd255,0,0,0,S_BAL));
        vt.push_back(mk(1,1,1,0,1,    1,8'd255,1,0,0,S_STEER));
        vt.push_back(mk(1,1,0,0,3,    1,8'd255,1,0,0,S_STEER));
        // rider step-off
        vt.push_back(mk(1,0,1,0,1,    1,8'd255,0,1,0,S_BAL));
        vt.push_back(mk(1,0,1,0,1,    1,8'd255,0,0,0,S_BAL));
        vt.push_back(mk(1,1,1,0,256,  1,8'd255,1,0,0,S_STEER));
        // overspeed bursts
        vt.push_back(mk(1,1,1,1,7,    1,8'd255,1,0,0,S_STEER));
        vt.push_back(mk(1,1,1,0,1,    1,8'd255,1,0,0,S_STEER));
        vt.push_back(mk(1,1,1,1,7,    1,8'd255,1,0,0,S_STEER));
        vt.push_back(mk(1,1,1,1,1,    0,8'd0,  0,0,1,S_FAULT));
        vt.push_back(mk(1,1,1,0,10,   0,8'd0,  0,0,1,S_FAULT));
        vt.push_back(mk(0,0,0,0,1,    0,8'd0,  0,0,0,S_OFF));
        vt.push_back(mk(1,0,0,0,1,    1,8'd0,  0,0,0,S_RAMP));
        vt.push_back(mk(1,0,0,0,16,   1,8'd1,  0,0,0,S_RAMP));
        // request drop mid-ramp at 0x40
        vt.push_back(mk(1,0,0,0,1008, 1,8'h40, 0,0,0,S_RAMP));
        vt.push_back(mk(0,0,0,0,1,    0,8'd0,  0,0,0,S_OFF));
        // request drop on the same edge as a fault trip
        vt.push_back(mk(1,0,0,1,8,    1,8'd0,  0,0,0,S_RAMP));
        vt.push_back(mk(0,0,0,1,1,    0,8'd0,  0,0,0,S_OFF));

        foreach (vt[i]) begin
            repeat (vt[i].n) step_d(vt[i].p, vt[i].s, vt[i].d, vt[i].t);
            check($sformatf("vec%0d", i), d_bundle(),
                  {1'b0, vt[i].st, vt[i].pu, vt[i].ss, vt[i].en, vt[i].ro, vt[i].f});
        end

        // asynchronous reset while steering
        repeat (4081) step_d(1, 0, 0, 0);
        repeat (256) step_d(1, 1, 1, 0);
        check("pre_reset_steer", d_bundle(), {1'b0, S_STEER, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_steer", d_bundle(), 16'h0000);
        @(posedge clk);
        #1;
        check("held_reset", d_bundle(), 16'h0000);
        @(negedge clk);
        p = 0; s = 0; d = 0; t = 0;
        rst_n = 1'b1;

        // ramp saturation on the small instance: 0 -> 100 -> 200 -> 255
        step_r(1, 0, 0, 0);
        repeat (3) step_r(1, 0, 0, 0);
        check("sat_e4", {5'd0, r_state, r_ss}, {5'd0, S_RAMP, 8'd0});
        step_r(1, 0, 0, 0);
        check("sat_e5", {5'd0, r_state, r_ss}, {5'd0, S_RAMP, 8'd100});
        repeat (4) step_r(1, 0, 0, 0);
        check("sat_e9", {5'd0, r_state, r_ss}, {5'd0, S_RAMP, 8'd200});
        repeat (3) step_r(1, 0, 0, 0);
        check("sat_e12", {5'd0, r_state, r_ss}, {5'd0, S_RAMP, 8'd200});
        step_r(1, 0, 0, 0);
        check("sat_e13", {5'd0, r_state, r_ss}, {5'd0, S_BAL, 8'd255});

        // random stimulus against the model
        @(negedge clk);
        rp = 0; rs = 0; rd = 0; rt = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_mode = 0; m_ramp = 0; m_run = 0; m_fast = 0; m_ro = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic ip, is, id, it;
            ip = ($urandom_range(99) >= 2);
            is = ($urandom_range(99) < 85);
            id = ($urandom_range(99) < 85);
            it = ($urandom_range(99) < 25);
            step_r(ip, is, id, it);
            model_step(ip, is, id, it);
            check($sformatf("rand%0d", i), {4'd0, r_pu, r_ss, r_en, r_ro, r_f}, {4'd0, model_out()});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
